// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner codes, streak width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbIBusy   = 2'd1,
    ArbDBusy   = 2'd2,
    ArbRelease = 2'd3
  } arb_state_e;

  localparam logic [1:0] OwnNone = 2'd0;
  localparam logic [1:0] OwnI    = 2'd1;
  localparam logic [1:0] OwnD    = 2'd2;

  localparam int unsigned StreakW = 3;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant picker: D wins unless it has starved a pending I request long enough.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DPRIO_MAX = 4
) (
  input  logic               i_req_i,
  input  logic               d_req_i,
  input  logic [StreakW-1:0] d_streak_i,
  output logic               grant_i_o,
  output logic               grant_d_o
);

  localparam logic [StreakW-1:0] DprioMax = StreakW'(DPRIO_MAX);

  always_comb begin
    grant_d_o = d_req_i && (!i_req_i || (d_streak_i < DprioMax));
    grant_i_o = i_req_i && !grant_d_o;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single memory-controller port; one transaction outstanding.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CLSIZE    = 128,
  parameter int unsigned DPRIO_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_strobe_i,
  input  logic [XLEN-1:0]   i_addr_i,
  output logic              i_done_o,
  output logic [CLSIZE-1:0] i_data_o,
  input  logic              d_strobe_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic              d_rw_i,
  input  logic [CLSIZE-1:0] d_data_i,
  output logic              d_done_o,
  output logic [CLSIZE-1:0] d_data_o,
  output logic              M_MEM_strobe_o,
  output logic [XLEN-1:0]   M_MEM_addr_o,
  output logic              M_MEM_rw_o,
  output logic [CLSIZE-1:0] M_MEM_data_o,
  input  logic              M_MEM_done_i,
  input  logic [CLSIZE-1:0] M_MEM_data_i,
  output logic [1:0]        owner_o
);

  localparam logic [StreakW-1:0] DprioMax = StreakW'(DPRIO_MAX);

  arb_state_e          state_q, state_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [CLSIZE-1:0]   data_q, data_d;
  logic [StreakW-1:0]  d_streak_q, d_streak_d;
  logic                grant_i, grant_d;

  mem_arb_pick #(
    .DPRIO_MAX(DPRIO_MAX)
  ) u_pick (
    .i_req_i   (i_strobe_i),
    .d_req_i   (d_strobe_i),
    .d_streak_i(d_streak_q),
    .grant_i_o (grant_i),
    .grant_d_o (grant_d)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    data_d     = data_q;
    d_streak_d = d_streak_q;
    unique case (state_q)
      ArbIdle: begin
        if (grant_d) begin
          state_d = ArbDBusy;
          addr_d  = d_addr_i;
          rw_d    = d_rw_i;
          data_d  = d_data_i;
          // Streak only grows while I is actually being held off.
          if (!i_strobe_i) begin
            d_streak_d = '0;
          end else if (d_streak_q < DprioMax) begin
            d_streak_d = d_streak_q + 1'b1;
          end
        end else if (grant_i) begin
          state_d    = ArbIBusy;
          addr_d     = i_addr_i;
          rw_d       = 1'b0;
          data_d     = '0;
          d_streak_d = '0;
        end
      end
      ArbIBusy, ArbDBusy: begin
        if (M_MEM_done_i) state_d = ArbRelease;
      end
      ArbRelease: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ArbIdle;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      data_q     <= '0;
      d_streak_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      data_q     <= data_d;
      d_streak_q <= d_streak_d;
    end
  end

  // Strobe and owner decode straight from state so reset drops them without a clock edge.
  always_comb begin
    M_MEM_strobe_o = (state_q == ArbIBusy) || (state_q == ArbDBusy);
    M_MEM_addr_o   = addr_q;
    M_MEM_rw_o     = rw_q;
    M_MEM_data_o   = data_q;
    owner_o        = (state_q == ArbIBusy) ? OwnI :
                     (state_q == ArbDBusy) ? OwnD : OwnNone;
    i_done_o       = (state_q == ArbIBusy) && M_MEM_done_i;
    d_done_o       = (state_q == ArbDBusy) && M_MEM_done_i;
    i_data_o       = M_MEM_data_i;
    d_data_o       = M_MEM_data_i;
  end

endmodule
